// File: rtl/tsb_mc_if.sv
// Port bundle for tsb_mc: child-manager task inputs, retry, network enqueue/response,
// child-manager responses and buffer status.
interface tsb_mc_if #(
    parameter int N_IN    = 2,
    parameter int LOG_DEPTH = 4,
    parameter int TASK_W  = 64,
    parameter int TS_W    = 32,
    parameter int TILE_W  = 7,
    parameter int CQ_W    = 4,
    parameter int CHILD_W = 4,
    parameter int EPOCH_W = 8,
    parameter int TQ_W    = 6,
    parameter int CH_W    = (N_IN > 1) ? $clog2(N_IN) : 1
);
    logic [2:0]                       log_n_tiles;
    logic [N_IN-1:0]                  s_wvalid;
    logic [N_IN-1:0]                  s_wready;
    logic [N_IN-1:0][TASK_W-1:0]      s_wdata;
    logic [N_IN-1:0]                  s_tied;
    logic [N_IN-1:0][CQ_W-1:0]        s_cq_slot;
    logic [N_IN-1:0][CHILD_W-1:0]     s_child_id;
    logic                             s_only_untied;
    logic                             retry_valid;
    logic                             retry_ready;
    logic [LOG_DEPTH-1:0]             retry_tsb_id;
    logic                             retry_abort;
    logic                             retry_tied;
    logic                             task_enq_valid;
    logic                             task_enq_ready;
    logic [TASK_W-1:0]                task_enq_data;
    logic                             task_enq_tied;
    logic [TILE_W-1:0]                task_enq_dest_tile;
    logic [LOG_DEPTH-1:0]             task_enq_tsb_id;
    logic                             task_resp_valid;
    logic                             task_resp_ready;
    logic                             task_resp_ack;
    logic [LOG_DEPTH-1:0]             task_resp_tsb_id;
    logic [EPOCH_W-1:0]               task_resp_epoch;
    logic [TQ_W-1:0]                  task_resp_tq_slot;
    logic                             m_resp_valid;
    logic                             m_resp_ready;
    logic [CH_W-1:0]                  m_resp_chan;
    logic                             m_resp_ack;
    logic [LOG_DEPTH-1:0]             m_tsb_slot;
    logic [EPOCH_W-1:0]               m_epoch;
    logic [TQ_W-1:0]                  m_tq_slot;
    logic [TILE_W-1:0]                m_tile_id;
    logic [CQ_W-1:0]                  m_cq_slot;
    logic [CHILD_W-1:0]               m_child_id;
    logic [LOG_DEPTH:0]               occupancy;
    logic [TS_W-1:0]                  lvt;
    logic                             empty;

    modport slave (
        input  log_n_tiles, s_wvalid, s_wdata, s_tied, s_cq_slot, s_child_id,
               retry_valid, retry_tsb_id, retry_abort, retry_tied, task_enq_ready,
               task_resp_valid, task_resp_ack, task_resp_tsb_id, task_resp_epoch,
               task_resp_tq_slot, m_resp_ready,
        output s_wready, s_only_untied, retry_ready, task_enq_valid, task_enq_data,
               task_enq_tied, task_enq_dest_tile, task_enq_tsb_id, task_resp_ready,
               m_resp_valid, m_resp_chan, m_resp_ack, m_tsb_slot, m_epoch, m_tq_slot,
               m_tile_id, m_cq_slot, m_child_id, occupancy, lvt, empty
    );

    modport master (
        output log_n_tiles, s_wvalid, s_wdata, s_tied, s_cq_slot, s_child_id,
               retry_valid, retry_tsb_id, retry_abort, retry_tied, task_enq_ready,
               task_resp_valid, task_resp_ack, task_resp_tsb_id, task_resp_epoch,
               task_resp_tq_slot, m_resp_ready,
        input  s_wready, s_only_untied, retry_ready, task_enq_valid, task_enq_data,
               task_enq_tied, task_enq_dest_tile, task_enq_tsb_id, task_resp_ready,
               m_resp_valid, m_resp_chan, m_resp_ack, m_tsb_slot, m_epoch, m_tq_slot,
               m_tile_id, m_cq_slot, m_child_id, occupancy, lvt, empty
    );
endinterface

// File: rtl/tsb_mc.sv
// Multi-channel task send buffer: round-robin merge of child-manager tasks into one enqueue
// port, entries held until ACK or retry-abort, tied responses routed back, rolling LVT scan.
module tsb_mc #(
    parameter int N_IN           = 2,
    parameter int LOG_DEPTH      = 4,
    parameter int UNTIED_RESERVE = 3,
    parameter int TASK_W         = 64,
    parameter int TS_W           = 32,
    parameter int TILE_W         = 7,
    parameter int CQ_W           = 4,
    parameter int CHILD_W        = 4,
    parameter int EPOCH_W        = 8,
    parameter int TQ_W           = 6,
    parameter int CH_W           = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic     clk,
    input  logic     rstn,
    tsb_mc_if.slave  bus
);
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam int OCC_W = LOG_DEPTH + 1;

    logic [DEPTH-1:0]               ent_valid, ent_tied;
    logic [DEPTH-1:0][TASK_W-1:0]   ent_task;
    logic [DEPTH-1:0][TILE_W-1:0]   ent_tile;
    logic [DEPTH-1:0][CQ_W-1:0]     ent_cq;
    logic [DEPTH-1:0][CHILD_W-1:0]  ent_child;
    logic [DEPTH-1:0][CH_W-1:0]     ent_chan;

    logic [CH_W-1:0]      rr_ptr, gnt;
    logic                 gnt_vld, free_any, osf, take, retry_fire, resp_fire;
    logic                 dec_abort, dec_resp;
    logic [LOG_DEPTH-1:0] free_idx, scan_idx, r_id, a_id;
    logic [OCC_W-1:0]     occ;
    logic [TS_W-1:0]      rolling, scan_ts;
    logic [15:0]          gnt_hint;
    logic [TILE_W-1:0]    gnt_tile;

    assign r_id       = bus.retry_tsb_id;
    assign a_id       = bus.task_resp_tsb_id;
    assign osf        = !bus.task_enq_valid || bus.task_enq_ready;
    assign retry_fire = bus.retry_valid && osf;
    assign take       = osf && !bus.retry_valid && free_any && gnt_vld;
    assign resp_fire  = bus.task_resp_valid && bus.task_resp_ready;

    assign bus.retry_ready     = osf;
    assign bus.task_resp_ready = !bus.m_resp_valid || bus.m_resp_ready;
    assign bus.occupancy       = occ;
    assign bus.empty           = (occ == '0);
    assign bus.s_only_untied   = occ > OCC_W'(DEPTH - UNTIED_RESERVE);

    // An abort and an ACK naming the same entry must only release it once.
    assign dec_abort = retry_fire && bus.retry_abort && ent_valid[r_id];
    assign dec_resp  = resp_fire && bus.task_resp_ack && ent_valid[a_id] &&
                       !(dec_abort && (a_id == r_id));

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = LOG_DEPTH'(i);
            end
        end
    end

    // Walk downward so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int c;
        logic [CH_W-1:0] ci;
        c       = 0;
        ci      = '0;
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            c = int'(rr_ptr) + k;
            if (c >= N_IN) c = c - N_IN;
            ci = CH_W'(c);
            if (bus.s_wvalid[ci]) begin
                gnt_vld = 1'b1;
                gnt     = ci;
            end
        end
    end

    always_comb begin
        bus.s_wready = '0;
        for (int ch = 0; ch < N_IN; ch++)
            bus.s_wready[ch] = take && (gnt == CH_W'(ch));
    end

    assign gnt_hint = bus.s_wdata[gnt][TS_W +: 16];
    assign gnt_tile = TILE_W'((gnt_hint >> 4) & ((16'd1 << bus.log_n_tiles) - 16'd1));
    assign scan_ts  = ent_task[scan_idx][TS_W-1:0];

    always_ff @(posedge clk) begin
        if (take) begin
            ent_task[free_idx]  <= bus.s_wdata[gnt];
            ent_tile[free_idx]  <= gnt_tile;
            ent_cq[free_idx]    <= bus.s_cq_slot[gnt];
            ent_child[free_idx] <= bus.s_child_id[gnt];
            ent_chan[free_idx]  <= gnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_valid              <= '0;
            ent_tied               <= '0;
            rr_ptr                 <= '0;
            occ                    <= '0;
            scan_idx               <= '0;
            rolling                <= '1;
            bus.lvt                <= '0;
            bus.task_enq_valid     <= 1'b0;
            bus.task_enq_data      <= '0;
            bus.task_enq_tied      <= 1'b0;
            bus.task_enq_dest_tile <= '0;
            bus.task_enq_tsb_id    <= '0;
            bus.m_resp_valid       <= 1'b0;
            bus.m_resp_chan        <= '0;
            bus.m_resp_ack         <= 1'b0;
            bus.m_tsb_slot         <= '0;
            bus.m_epoch            <= '0;
            bus.m_tq_slot          <= '0;
            bus.m_tile_id          <= '0;
            bus.m_cq_slot          <= '0;
            bus.m_child_id         <= '0;
        end else begin
            if (dec_abort) ent_valid[r_id] <= 1'b0;
            if (dec_resp)  ent_valid[a_id] <= 1'b0;
            if (take) begin
                ent_valid[free_idx] <= 1'b1;
                ent_tied[free_idx]  <= bus.s_tied[gnt];
                rr_ptr              <= (int'(gnt) == N_IN - 1) ? '0 : gnt + 1'b1;
            end

            if (retry_fire && !bus.retry_abort) begin
                ent_tied[r_id]         <= bus.retry_tied;
                bus.task_enq_valid     <= 1'b1;
                bus.task_enq_data      <= ent_task[r_id];
                bus.task_enq_tied      <= bus.retry_tied;
                bus.task_enq_dest_tile <= ent_tile[r_id];
                bus.task_enq_tsb_id    <= r_id;
            end else if (take) begin
                bus.task_enq_valid     <= 1'b1;
                bus.task_enq_data      <= bus.s_wdata[gnt];
                bus.task_enq_tied      <= bus.s_tied[gnt];
                bus.task_enq_dest_tile <= gnt_tile;
                bus.task_enq_tsb_id    <= free_idx;
            end else if (bus.task_enq_ready) begin
                bus.task_enq_valid     <= 1'b0;
            end

            occ <= occ + OCC_W'(take) - OCC_W'(dec_abort) - OCC_W'(dec_resp);

            if (resp_fire && ent_tied[a_id]) begin
                bus.m_resp_valid <= 1'b1;
                bus.m_resp_chan  <= ent_chan[a_id];
                bus.m_resp_ack   <= bus.task_resp_ack;
                bus.m_tsb_slot   <= a_id;
                bus.m_epoch      <= bus.task_resp_epoch;
                bus.m_tq_slot    <= bus.task_resp_tq_slot;
                bus.m_tile_id    <= ent_tile[a_id];
                bus.m_cq_slot    <= ent_cq[a_id];
                bus.m_child_id   <= ent_child[a_id];
            end else if (bus.m_resp_ready) begin
                bus.m_resp_valid <= 1'b0;
            end

            // One entry per cycle; the minimum of a full sweep is published at idx 0.
            if (scan_idx == '0) begin
                bus.lvt <= rolling;
                rolling <= ent_valid[0] ? scan_ts : '1;
            end else if (ent_valid[scan_idx] && (scan_ts < rolling)) begin
                rolling <= scan_ts;
            end
            scan_idx <= scan_idx + 1'b1;
        end
    end
endmodule
